keccak_round_ctrl: RTL

Sequencer for the Keccak-f[1600] permutation used by the SHA3-512 core. It owns the 1600-bit state register and an 8-bit round counter, and iterates the external combinational round function (theta, rho, pi, chi, iota) once per clock for ROUNDS rounds. It drives the round number consumed by the iota stage and exposes a valid/ready handshake towards the absorb/squeeze logic.

---
 rtl/keccak_round_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/keccak_round_ctrl.sv
// keccak_round_ctrl: sequencer for the Keccak-f[1600] permutation.
// Owns the 1600-bit state register and the round counter. It feeds the
// external combinational round function one round per clock and hands the
// permuted state out over a valid/ready handshake.
// Build macro: KECCAK_ABORT_EN adds the inAbort port, which cancels a
// permutation in flight.
module keccak_round_ctrl #(
    parameter int unsigned ROUNDS = 24
) (
    input  logic          inClk,
    input  logic          inReset,
`ifdef KECCAK_ABORT_EN
    input  logic          inAbort,
`endif
    input  logic          inValid,
    output logic          outReady,
    input  logic [1599:0] inData,
    output logic [7:0]    outRoundNumber,
    output logic [1599:0] outRoundState,
    input  logic [1599:0] inRoundResult,
    output logic          outValid,
    input  logic          inReady,
    output logic [1599:0] outData,
    output logic          outBusy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    cnt;
    logic [7:0]    cnt_nxt;
    logic [1599:0] st_reg;
    logic [1599:0] st_nxt;
    logic          abort;

`ifdef KECCAK_ABORT_EN
    assign abort = inAbort;
`else
    assign abort = 1'b0;
`endif

    // State, counter and Keccak state register; reset discards any block in flight.
    always_ff @(posedge inClk or posedge inReset) begin
        if (inReset) begin
            state  <= IDLE;
            cnt    <= '0;
            st_reg <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            st_reg <= st_nxt;
        end
    end

    // Next-state, counter and data-path selection.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        st_nxt    = st_reg;
        case (state)
            IDLE: begin
                if (inValid) begin
                    st_nxt    = inData;
                    cnt_nxt   = '0;
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                st_nxt = inRoundResult;
                if (cnt == LAST_ROUND) begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            DONE: begin
                if (inReady) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        // Abort overrides both the round update and the output handshake.
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            st_nxt    = '0;
        end
    end

    // Outputs decode from FSM and counter only, so no input reaches an output combinationally.
    assign outReady       = (state == IDLE);
    assign outValid       = (state == DONE);
    assign outBusy        = (state != IDLE);
    assign outRoundNumber = (state == ROUND) ? cnt : 8'd0;
    assign outRoundState  = st_reg;
    assign outData        = st_reg;

    // The counter runs 0..ROUNDS-1 and never wraps.
    a_cnt_range: assert property (@(posedge inClk) disable iff (inReset) (cnt <= LAST_ROUND));

endmodule
